// File: rtl/threshold_controller.sv
// Button-driven threshold selector: debounced key2/key3 step a pending value with
// auto-repeat, and the pending value is handed to the edge datapath only at frame_start.
//
// state    | meaning
// S_IDLE   | no key active, waiting for a single debounced press
// S_STEP   | one-cycle step of pending_threshold in the latched direction
// S_HOLD   | key still held, counting toward auto-repeat
// S_REPEAT | auto-repeat, one step every REPEAT_PERIOD cycles
// S_LOCK   | both keys seen, ignore everything until both are released
module threshold_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000,
  parameter int STEP            = 10,
  parameter int THRES_INIT      = 100,
  parameter int THRES_MIN       = 0,
  parameter int THRES_MAX       = 250
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       button2,
  input  logic       button3,
  input  logic       frame_start,
  output logic [7:0] pending_threshold,
  output logic [7:0] threshold,
  output logic       update_pending,
  output logic       threshold_applied
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HD_W = $clog2(REPEAT_DELAY + 1);
  localparam int RP_W = $clog2(REPEAT_PERIOD + 1);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HD_W-1:0] HD_LAST   = HD_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] RP_LAST   = RP_W'(REPEAT_PERIOD - 1);
  localparam logic [8:0]      STEP9     = 9'(STEP);
  localparam logic [8:0]      MAX9      = 9'(THRES_MAX);
  localparam logic [8:0]      DEC_FLOOR = 9'(THRES_MIN + STEP);
  localparam logic [7:0]      STEP8     = 8'(STEP);
  localparam logic [7:0]      MIN8      = 8'(THRES_MIN);
  localparam logic [7:0]      MAX8      = 8'(THRES_MAX);
  localparam logic [7:0]      INIT8     = 8'(THRES_INIT);

  typedef enum logic [2:0] {S_IDLE, S_STEP, S_HOLD, S_REPEAT, S_LOCK} state_t;

  state_t            r_state, w_state_nxt;
  logic [1:0]        w_btn, r_sync1, r_sync2, r_deb;
  logic [DB_W-1:0]   r_db_cnt [2];
  logic              w_p2, w_p3, w_lat, w_oth;
  logic              r_dir_up, w_dir_nxt;
  logic [HD_W-1:0]   r_hold_cnt, w_hold_nxt;
  logic [RP_W-1:0]   r_rep_cnt, w_rep_nxt;
  logic              w_step, w_load;
  logic [8:0]        w_inc;
  logic [7:0]        w_pend_stepped;
  logic [7:0]        r_pend, r_thr;
  logic              r_applied;

  // index 0 is key2 (increment), index 1 is key3 (decrement)
  assign w_btn = {button3, button2};

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1     <= 2'b11;
      r_sync2     <= 2'b11;
      r_deb       <= 2'b11;
      r_db_cnt[0] <= '0;
      r_db_cnt[1] <= '0;
    end else begin
      r_sync1 <= w_btn;
      r_sync2 <= r_sync1;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_deb[i]    <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign w_p2  = ~r_deb[0];
  assign w_p3  = ~r_deb[1];
  assign w_lat = r_dir_up ? w_p2 : w_p3;
  assign w_oth = r_dir_up ? w_p3 : w_p2;

  always_comb begin
    w_state_nxt = r_state;
    w_dir_nxt   = r_dir_up;
    w_hold_nxt  = r_hold_cnt;
    w_rep_nxt   = r_rep_cnt;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_p2 && w_p3) begin
          w_state_nxt = S_LOCK;
        end else if (w_p2 || w_p3) begin
          w_state_nxt = S_STEP;
          w_dir_nxt   = w_p2;
        end
      end
      S_STEP: begin
        // the step is already committed; a second key only blocks further steps
        w_step      = 1'b1;
        w_hold_nxt  = '0;
        w_state_nxt = w_oth ? S_LOCK : S_HOLD;
      end
      S_HOLD: begin
        if (w_oth) begin
          w_state_nxt = S_LOCK;
        end else if (!w_lat) begin
          w_state_nxt = S_IDLE;
        end else if (r_hold_cnt == HD_LAST) begin
          w_state_nxt = S_REPEAT;
          w_rep_nxt   = '0;
        end else begin
          w_hold_nxt = r_hold_cnt + HD_W'(1);
        end
      end
      S_REPEAT: begin
        if (w_oth) begin
          w_state_nxt = S_LOCK;
        end else if (!w_lat) begin
          w_state_nxt = S_IDLE;
        end else if (r_rep_cnt == RP_LAST) begin
          w_step    = 1'b1;
          w_rep_nxt = '0;
        end else begin
          w_rep_nxt = r_rep_cnt + RP_W'(1);
        end
      end
      S_LOCK: begin
        if (!w_p2 && !w_p3) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // bounds are compared at 9 bits so a step can never wrap the 8-bit value
  assign w_inc = {1'b0, r_pend} + STEP9;

  always_comb begin
    w_pend_stepped = r_pend;
    if (r_dir_up) begin
      w_pend_stepped = (w_inc > MAX9) ? MAX8 : w_inc[7:0];
    end else begin
      w_pend_stepped = ({1'b0, r_pend} < DEC_FLOOR) ? MIN8 : (r_pend - STEP8);
    end
  end

  assign update_pending = (r_pend != r_thr);
  assign w_load         = frame_start & update_pending;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_dir_up   <= 1'b0;
      r_hold_cnt <= '0;
      r_rep_cnt  <= '0;
      r_pend     <= INIT8;
      r_thr      <= INIT8;
      r_applied  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_dir_up   <= w_dir_nxt;
      r_hold_cnt <= w_hold_nxt;
      r_rep_cnt  <= w_rep_nxt;
      r_applied  <= w_load;
      if (w_load) r_thr <= r_pend;
      if (w_step) r_pend <= w_pend_stepped;
    end
  end

  assign pending_threshold = r_pend;
  assign threshold         = r_thr;
  assign threshold_applied = r_applied;

endmodule

// File: tb/tb_threshold_controller.sv
// Bench for threshold_controller: directed scenarios with literal expectations plus
// randomized key/frame traffic checked every cycle against a timing-based reference model.
module tb_threshold_controller;
  localparam int DB = 4, RD = 20, RP = 5, STEP = 10, INIT = 100, TMIN = 0, TMAX = 250;

  logic       clock = 1'b0, reset_n = 1'b0;
  logic       button2 = 1'b1, button3 = 1'b1, frame_start = 1'b0;
  logic [7:0] pending_threshold, threshold;
  logic       update_pending, threshold_applied;
  int         total = 0, bad = 0;

  always #5 clock = ~clock;

  threshold_controller #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP),
    .STEP(STEP), .THRES_INIT(INIT), .THRES_MIN(TMIN), .THRES_MAX(TMAX)
  ) dut (
    .clock(clock), .reset_n(reset_n), .button2(button2), .button3(button3),
    .frame_start(frame_start), .pending_threshold(pending_threshold),
    .threshold(threshold), .update_pending(update_pending),
    .threshold_applied(threshold_applied)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a key session starts on a debounced press seen while idle; steps fall
  // at session offset 0 and at RD + k*RP (k >= 1) while the key stays held.
  int   m_pend, m_thr, m_mode, m_start, m_cyc;
  int   m_run [2];
  bit   m_app, m_up;
  bit [1:0] m_s1, m_s2, m_deb;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_pend = INIT; m_thr = INIT; m_app = 0; m_mode = 0; m_start = 0; m_cyc = 0;
      m_up = 0; m_s1 = 2'b11; m_s2 = 2'b11; m_deb = 2'b11; m_run[0] = 0; m_run[1] = 0;
    end else begin : model_step
      bit p2, p3, lat, oth, step;
      int e;
      p2 = !m_deb[0]; p3 = !m_deb[1]; step = 0;
      case (m_mode)
        0: if (p2 && p3) m_mode = 2;
           else if (p2 || p3) begin m_mode = 1; m_up = p2; m_start = m_cyc + 1; end
        1: begin
          lat = m_up ? p2 : p3; oth = m_up ? p3 : p2; e = m_cyc - m_start;
          if (e == 0) begin step = 1; if (oth) m_mode = 2; end
          else if (oth) m_mode = 2;
          else if (!lat) m_mode = 0;
          else if (e >= RD + RP && (e - RD) % RP == 0) step = 1;
        end
        default: if (!p2 && !p3) m_mode = 0;
      endcase
      m_app = frame_start && (m_pend != m_thr);
      if (m_app) m_thr = m_pend;
      if (step) begin
        if (m_up) m_pend = (m_pend + STEP > TMAX) ? TMAX : m_pend + STEP;
        else      m_pend = (m_pend - STEP < TMIN) ? TMIN : m_pend - STEP;
      end
      for (int i = 0; i < 2; i++) begin
        if (m_s2[i] == m_deb[i]) m_run[i] = 0;
        else begin
          m_run[i]++;
          if (m_run[i] == DB) begin m_deb[i] = m_s2[i]; m_run[i] = 0; end
        end
      end
      m_s2 = m_s1;
      m_s1 = {button3, button2};
      m_cyc++;
    end
  end

  always @(posedge clock) begin
    #1;
    check("pending", pending_threshold, m_pend);
    check("threshold", threshold, m_thr);
    check("update_pending", update_pending, int'(m_pend != m_thr));
    check("applied", threshold_applied, int'(m_app));
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  // key: 2 = key2, 3 = key3, 5 = both
  task automatic press(input int key, input int n, input int gap);
    button2 = !(key == 2 || key == 5);
    button3 = !(key == 3 || key == 5);
    cycles(n);
    button2 = 1'b1; button3 = 1'b1;
    cycles(gap);
  endtask

  task automatic do_reset();
    reset_n = 1'b0; cycles(2);
    reset_n = 1'b1; cycles(2);
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1; cycles(1); frame_start = 1'b0;
  endtask

  initial begin
    cycles(3);
    check("rst_pending", pending_threshold, 100);
    check("rst_threshold", threshold, 100);
    check("rst_upd", update_pending, 0);
    check("rst_applied", threshold_applied, 0);
    reset_n = 1'b1; cycles(2);

    press(2, 10, 12);
    check("single_pending", pending_threshold, 110);
    check("single_thr_held", threshold, 100);
    check("single_upd", update_pending, 1);
    frame_pulse();
    check("single_applied", threshold_applied, 1);
    check("single_thr_loaded", threshold, 110);
    cycles(1);
    check("single_applied_end", threshold_applied, 0);
    check("single_upd_clear", update_pending, 0);
    frame_pulse();
    check("no_pending_no_pulse", threshold_applied, 0);

    press(2, 200, 12);
    check("sat_reach_max", pending_threshold, 250);
    repeat (3) press(2, 10, 12);
    check("sat_max_hold", pending_threshold, 250);
    press(3, 400, 12);
    check("sat_reach_min", pending_threshold, 0);
    press(3, 10, 12);
    check("sat_min_hold", pending_threshold, 0);

    do_reset();
    press(3, 50, 12);
    check("autorepeat_50", pending_threshold, 40);

    do_reset();
    for (int i = 0; i < 5; i++) begin
      button2 = 1'b0; cycles(2);
      button2 = 1'b1; cycles(2);
    end
    cycles(12);
    check("bounce_no_step", pending_threshold, 100);

    press(2, 10, 12);
    button2 = 1'b0; cycles(7);
    frame_start = 1'b1; cycles(1); frame_start = 1'b0;
    check("coinc_old_applied", threshold, 110);
    check("coinc_new_pending", pending_threshold, 120);
    check("coinc_pulse", threshold_applied, 1);
    cycles(2); button2 = 1'b1; cycles(12);
    check("coinc_still_pending", update_pending, 1);
    frame_pulse();
    check("coinc_next_frame", threshold, 120);

    press(5, 30, 12);
    check("lock_both", pending_threshold, 120);
    button2 = 1'b0; cycles(15);
    button3 = 1'b0; cycles(25);
    button2 = 1'b1; button3 = 1'b1; cycles(12);
    check("lock_second_in_hold", pending_threshold, 130);

    do_reset();
    button2 = 1'b0; cycles(60);
    check("repeat_at_170", pending_threshold, 170);
    reset_n = 1'b0; #1;
    check("async_rst_pending", pending_threshold, 100);
    check("async_rst_thr", threshold, 100);
    check("async_rst_upd", update_pending, 0);
    cycles(1); reset_n = 1'b1;
    cycles(7);
    check("redebounce_wait", pending_threshold, 100);
    cycles(1);
    check("redebounce_step", pending_threshold, 110);
    button2 = 1'b1; cycles(12);

    do_reset();
    repeat (120) begin
      int kind, len;
      kind = $urandom_range(0, 5);
      len  = (kind == 1 || kind == 2) ? $urandom_range(1, 150) : $urandom_range(1, 40);
      for (int i = 0; i < len; i++) begin
        case (kind)
          1: begin button2 = 1'b0; button3 = 1'b1; end
          2: begin button2 = 1'b1; button3 = 1'b0; end
          3: begin button2 = 1'b0; button3 = 1'b0; end
          4: begin button2 = 1'($urandom_range(0, 1)); button3 = 1'b1; end
          default: begin button2 = 1'b1; button3 = 1'b1; end
        endcase
        frame_start = ($urandom_range(0, 7) == 0);
        @(negedge clock);
      end
    end
    button2 = 1'b1; button3 = 1'b1; frame_start = 1'b0;
    cycles(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
